// File: rtl/div_ctrl.sv
// EX-stage controller in front of the multicycle divider: sign handling, HI/LO write, stall and flush drain.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor bypasses the divider (lo=all ones, hi=op_a).
module div_ctrl #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_start,
  input  logic                 div_signed,
  input  logic [DATAWIDTH-1:0] op_a,
  input  logic [DATAWIDTH-1:0] op_b,
  input  logic                 annul,
  output logic                 stall_req,
  output logic                 hilo_we,
  output logic [DATAWIDTH-1:0] hi_o,
  output logic [DATAWIDTH-1:0] lo_o,
  output logic                 div_en,
  output logic [DATAWIDTH-1:0] div_dividend,
  output logic [DATAWIDTH-1:0] div_divisor,
  input  logic                 div_ready,
  input  logic                 div_vld,
  input  logic [DATAWIDTH-1:0] div_quotient,
  input  logic [DATAWIDTH-1:0] div_remainder
);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, FIX, DONE, DRAIN, ZERO} state_t;

  state_t               state, state_nx;
  logic                 sign_q, sign_r;
  logic [DATAWIDTH-1:0] q_raw, r_raw;
  logic                 sa, sb, accept, zero_div;
  logic [DATAWIDTH-1:0] mag_a, mag_b;

  assign sa     = div_signed & op_a[DATAWIDTH-1];
  assign sb     = div_signed & op_b[DATAWIDTH-1];
  // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct unsigned magnitude
  assign mag_a  = sa ? -op_a : op_a;
  assign mag_b  = sb ? -op_b : op_b;
  assign accept = (state == IDLE) & div_start & ~annul;

`ifdef DIV_ZERO_FASTPATH_EN
  assign zero_div = (op_b == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = zero_div ? ZERO : ISSUE;
      ISSUE: if (annul) state_nx = IDLE;
             else if (div_ready) state_nx = BUSY;
      // a result arriving with the flush means the divider is already idle: skip DRAIN
      BUSY:  if (div_vld) state_nx = annul ? IDLE : FIX;
             else if (annul) state_nx = DRAIN;
      FIX:   state_nx = annul ? IDLE : DONE;
      ZERO:  state_nx = annul ? IDLE : DONE;
      DONE:  state_nx = IDLE;
      DRAIN: if (div_vld) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    div_en    = 1'b0;
    hilo_we   = 1'b0;
    case (state)
      IDLE:            stall_req = div_start & ~annul;
      ISSUE: begin
        stall_req = 1'b1;
        div_en    = div_ready & ~annul;
      end
      BUSY, FIX, ZERO: stall_req = 1'b1;
      DONE:            hilo_we   = ~annul;
      DRAIN:           stall_req = div_start;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      q_raw        <= '0;
      r_raw        <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
    end else begin
      if (accept) begin
        sign_q <= sa ^ sb;
        sign_r <= sa;
        if (zero_div) begin
          r_raw <= op_a;
        end else begin
          div_dividend <= mag_a;
          div_divisor  <= mag_b;
        end
      end
      if (state == BUSY && div_vld) begin
        q_raw <= div_quotient;
        r_raw <= div_remainder;
      end
      if (state == FIX && !annul) begin
        lo_o <= sign_q ? -q_raw : q_raw;
        hi_o <= sign_r ? -r_raw : r_raw;
      end
      if (state == ZERO && !annul) begin
        lo_o <= '1;
        hi_o <= r_raw;
      end
    end
  end

endmodule
